rwt_up_bus_splitter: RTL and testbench
======================================

// Module: rwt_up_bus_splitter
// PURPOSE
//  Registered one-to-N splitter for the up_* register bus. Sits between up_axi and NUM_BLOCKS register blocks.
//  Decodes the upper address bits to pick a block and forwards each request as a one-cycle pulse.
//  Tracks each outstanding read and write and ends it with an ack upstream.
//  Adds a per-channel ack timeout, out-of-range error completion and a saturating error counter.
// PARAMETERS
//  NUM_BLOCKS  1            number of downstream blocks, 1..2**SEL_WIDTH
//  SEL_WIDTH   5            upper address bits that select the block
//  LOCAL_AW    9            address bits passed to each block
//  TIMEOUT     256          cycles to wait for a block ack before forcing completion, 2..65535
//  ERR_DATA    32'hDEADDEAD read data returned on timeout or out-of-range read
// PORTS
//  up_clk        in   1                        bus clock; only clock
//  up_rstn       in   1                        asynchronous active-low reset
//  up_wreq       in   1                        upstream write request pulse
//  up_waddr      in   SEL_WIDTH+LOCAL_AW       upstream write address
//  up_wdata      in   32                       upstream write data
//  up_wack       out  1                        upstream write ack pulse
//  up_rreq       in   1                        upstream read request pulse
//  up_raddr      in   SEL_WIDTH+LOCAL_AW       upstream read address
//  up_rdata      out  32                       upstream read data, valid with up_rack
//  up_rack       out  1                        upstream read ack pulse
//  blk_wreq      out  NUM_BLOCKS               per-block write request, one-hot pulse
//  blk_waddr     out  LOCAL_AW                 block write address
//  blk_wdata     out  32                       block write data
//  blk_wack      in   NUM_BLOCKS               per-block write ack
//  blk_rreq      out  NUM_BLOCKS               per-block read request, one-hot pulse
//  blk_raddr     out  LOCAL_AW                 block read address
//  blk_rdata     in   32*NUM_BLOCKS            per-block read data, block i at [32*i +: 32]
//  blk_rack      in   NUM_BLOCKS               per-block read ack
//  err_clr       in   1                        clear the error counter (pulse)
//  err_timeout   out  1                        pulse: a transaction ended by timeout
//  err_decode    out  1                        pulse: a transaction hit an out-of-range block
//  err_cnt       out  16                       saturating count of timeout and decode errors
// BEHAVIOUR
//  Reset: every output is 0, both FSMs are IDLE, the timeout counters are 0 and err_cnt is 0.
//   Reset mid-transaction abandons it; no ack is issued afterwards.
//  Read and write channels are independent, each with one FSM (IDLE, WAIT, ERR), and may be busy at once.
//  IDLE, req at cycle N, sel = addr[SEL_WIDTH+LOCAL_AW-1:LOCAL_AW]:
//   sel < NUM_BLOCKS: at N+1 blk_*req[sel]=1 for exactly 1 cycle.
//    blk_*addr (and blk_wdata) are registered at N and held until the next request.
//    The FSM latches sel and goes to WAIT.
//   sel >= NUM_BLOCKS: no block request. Go to ERR; ack upstream at N+1.
//    On a read, up_rdata=ERR_DATA at N+1. err_decode pulses at N+1.
//  WAIT: only blk_*ack[latched sel] counts; acks from other blocks are ignored.
//   An ack is accepted from N+1 onward, including the cycle blk_*req is high.
//   Ack at cycle M: up_*ack=1 at M+1 for exactly 1 cycle.
//    up_rdata = blk_rdata[32*sel +: 32] sampled at M; the FSM returns to IDLE.
//  Timeout: the counter clears on entry to WAIT and increments every WAIT cycle.
//   If it reaches TIMEOUT-1 with no ack, the next cycle forces up_*ack.
//   On a read that ack carries up_rdata=ERR_DATA. err_timeout pulses with the ack; return to IDLE.
//   An ack arriving in the same cycle as the timeout wins and is a normal completion.
//  A late block ack arriving after completion (in IDLE) is ignored.
//  A new upstream req on a channel that is not IDLE is dropped; the upstream side never issues one.
//  Minimum round trip: req at N, block ack at N+1, upstream ack at N+2.
//  up_rdata holds its last value between acks; it is 0 after reset.
//  err_cnt adds 1 per err_timeout and 1 per err_decode, and +2 when both occur in the same cycle.
//   err_cnt saturates at 16'hFFFF. err_clr has priority and sets it to 0, dropping errors in that cycle.
//  All outputs are registered; there is no combinational path from input to output.
// TESTING
//  NUM_BLOCKS=3. Write 0x0205 data 0xA5A5A5A5 at N, blk1 acks at N+2
//   -> blk_wreq=3'b010 at N+1, blk_waddr=0x005, up_wack at N+3.
//  Read addr 0x0403, blk2 acks at N+1 with 0x12345678
//   -> blk_rreq=3'b100 at N+1; up_rack at N+2 with up_rdata=0x12345678.
//  Read addr 0x0A00 (sel=5)
//   -> no blk_rreq; up_rack at N+1 with 0xDEADDEAD; err_decode=1; err_cnt=1.
//  TIMEOUT=16, write to blk0 that never acks
//   -> up_wack and err_timeout at N+17; a blk_wack at N+20 is ignored.
//  Write to blk0 and read from blk2 in the same cycle, acks at N+3 and N+1
//   -> up_rack at N+2, up_wack at N+4; correct data; no errors.
//  Assert up_rstn low during WAIT, then release -> no ack; all outputs 0; a new read then completes normally.
//  Further checks:
//   blk1 acks during a read to blk0 -> the stray ack is ignored.
//   err_cnt preset near 16'hFFFF -> it stops at 16'hFFFF.
//   err_clr asserted together with an error -> err_cnt=0.

Source files
------------

// File: rtl/rwt_up_bus_splitter.sv
// Registered one-to-N splitter for the up_* register bus: address decode, one-cycle
// block request pulses, per-channel ack timeout, decode-error completion, error counter.

module rwt_up_chan #(
  parameter int NUM_BLOCKS = 1,
  parameter int SEL_WIDTH  = 5,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic [NUM_BLOCKS-1:0] blk_ack,
  output logic [NUM_BLOCKS-1:0] blk_req,
  output logic [NUM_BLOCKS-1:0] sel_oh,
  output logic                  take,
  output logic                  fin_ok,
  output logic                  fin_to,
  output logic                  fin_dec,
  output logic                  ack
);
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                state, state_d;
  logic [15:0]           cnt, cnt_d;
  logic [NUM_BLOCKS-1:0] req_oh, sel_oh_d;
  logic                  hit;

  always_comb begin
    req_oh = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) req_oh[i] = (32'(sel) == 32'(i));
  end

  // Only the latched block's ack counts; stray acks from others fall out here.
  assign hit = |(blk_ack & sel_oh);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sel_oh_d = sel_oh;
    take     = 1'b0;
    fin_ok   = 1'b0;
    fin_to   = 1'b0;
    fin_dec  = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (|req_oh) begin
          take     = 1'b1;
          sel_oh_d = req_oh;
          cnt_d    = '0;
          state_d  = WAIT;
        end else begin
          fin_dec = 1'b1;
          state_d = ERR;
        end
      end
      WAIT: begin
        if (hit) begin
          fin_ok  = 1'b1;
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          fin_to  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_oh  <= '0;
      blk_req <= '0;
      ack     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      sel_oh  <= sel_oh_d;
      blk_req <= take ? req_oh : '0;
      ack     <= fin_ok | fin_to | fin_dec;
    end
  end
endmodule

module rwt_up_bus_splitter #(
  parameter int          NUM_BLOCKS = 1,
  parameter int          SEL_WIDTH  = 5,
  parameter int          LOCAL_AW   = 9,
  parameter int          TIMEOUT    = 256,
  parameter logic [31:0] ERR_DATA   = 32'hDEADDEAD
) (
  input  logic                         up_clk,
  input  logic                         up_rstn,
  input  logic                         up_wreq,
  input  logic [SEL_WIDTH+LOCAL_AW-1:0] up_waddr,
  input  logic [31:0]                  up_wdata,
  output logic                         up_wack,
  input  logic                         up_rreq,
  input  logic [SEL_WIDTH+LOCAL_AW-1:0] up_raddr,
  output logic [31:0]                  up_rdata,
  output logic                         up_rack,
  output logic [NUM_BLOCKS-1:0]        blk_wreq,
  output logic [LOCAL_AW-1:0]          blk_waddr,
  output logic [31:0]                  blk_wdata,
  input  logic [NUM_BLOCKS-1:0]        blk_wack,
  output logic [NUM_BLOCKS-1:0]        blk_rreq,
  output logic [LOCAL_AW-1:0]          blk_raddr,
  input  logic [32*NUM_BLOCKS-1:0]     blk_rdata,
  input  logic [NUM_BLOCKS-1:0]        blk_rack,
  input  logic                         err_clr,
  output logic                         err_timeout,
  output logic                         err_decode,
  output logic [15:0]                  err_cnt
);
  localparam int AW = SEL_WIDTH + LOCAL_AW;

  logic [NUM_BLOCKS-1:0] w_oh, r_oh;
  logic                  w_take, w_ok, w_to, w_dec;
  logic                  r_take, r_ok, r_to, r_dec;
  logic [31:0]           rd_mux;
  logic                  to_any, dec_any;
  logic [16:0]           err_sum;
  logic [15:0]           err_cnt_q;

  rwt_up_chan #(.NUM_BLOCKS(NUM_BLOCKS), .SEL_WIDTH(SEL_WIDTH), .TIMEOUT(TIMEOUT)) u_wr (
    .clk(up_clk), .rst_n(up_rstn), .req(up_wreq), .sel(up_waddr[AW-1:LOCAL_AW]),
    .blk_ack(blk_wack), .blk_req(blk_wreq), .sel_oh(w_oh), .take(w_take),
    .fin_ok(w_ok), .fin_to(w_to), .fin_dec(w_dec), .ack(up_wack)
  );

  rwt_up_chan #(.NUM_BLOCKS(NUM_BLOCKS), .SEL_WIDTH(SEL_WIDTH), .TIMEOUT(TIMEOUT)) u_rd (
    .clk(up_clk), .rst_n(up_rstn), .req(up_rreq), .sel(up_raddr[AW-1:LOCAL_AW]),
    .blk_ack(blk_rack), .blk_req(blk_rreq), .sel_oh(r_oh), .take(r_take),
    .fin_ok(r_ok), .fin_to(r_to), .fin_dec(r_dec), .ack(up_rack)
  );

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_BLOCKS; i++)
      rd_mux = rd_mux | (blk_rdata[32*i +: 32] & {32{r_oh[i]}});
  end

  assign to_any  = w_to | r_to;
  assign dec_any = w_dec | r_dec;
  assign err_sum = {1'b0, err_cnt_q} + 17'(to_any) + 17'(dec_any);
  assign err_cnt = err_cnt_q;

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      blk_waddr   <= '0;
      blk_wdata   <= '0;
      blk_raddr   <= '0;
      up_rdata    <= '0;
      err_timeout <= 1'b0;
      err_decode  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (w_take) begin
        blk_waddr <= up_waddr[LOCAL_AW-1:0];
        blk_wdata <= up_wdata;
      end
      if (r_take) blk_raddr <= up_raddr[LOCAL_AW-1:0];
      if (r_ok)                up_rdata <= rd_mux;
      else if (r_to || r_dec)  up_rdata <= ERR_DATA;
      err_timeout <= to_any;
      err_decode  <= dec_any;
      // Clear wins over any error landing in the same cycle.
      if (err_clr)                     err_cnt_q <= '0;
      else if (to_any || dec_any)      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
endmodule

// File: tb/tb_rwt_up_bus_splitter.sv
// Bench for rwt_up_bus_splitter: directed scenarios plus randomized single transactions
// checked against arithmetic expectations for ack latency, data and error counting.

module tb_rwt_up_bus_splitter;
  localparam int NB  = 3;
  localparam int SW  = 5;
  localparam int LAW = 9;
  localparam int AW  = SW + LAW;
  localparam int TO  = 16;
  localparam logic [31:0] ED = 32'hDEADDEAD;

  logic            up_clk = 1'b0;
  logic            up_rstn;
  logic            up_wreq, up_rreq;
  logic [AW-1:0]   up_waddr, up_raddr;
  logic [31:0]     up_wdata, up_rdata;
  logic            up_wack, up_rack;
  logic [NB-1:0]   blk_wreq, blk_rreq, blk_wack, blk_rack;
  logic [LAW-1:0]  blk_waddr, blk_raddr;
  logic [31:0]     blk_wdata;
  logic [32*NB-1:0] blk_rdata;
  logic            err_clr, err_timeout, err_decode;
  logic [15:0]     err_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_err = '0;

  rwt_up_bus_splitter #(.NUM_BLOCKS(NB), .SEL_WIDTH(SW), .LOCAL_AW(LAW), .TIMEOUT(TO),
                        .ERR_DATA(ED)) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .blk_wreq(blk_wreq), .blk_waddr(blk_waddr), .blk_wdata(blk_wdata), .blk_wack(blk_wack),
    .blk_rreq(blk_rreq), .blk_raddr(blk_raddr), .blk_rdata(blk_rdata), .blk_rack(blk_rack),
    .err_clr(err_clr), .err_timeout(err_timeout), .err_decode(err_decode), .err_cnt(err_cnt)
  );

  always #5 up_clk = ~up_clk;

  task automatic step();
    @(posedge up_clk);
    #1;
  endtask

  // Expected upstream ack cycle (relative to the request cycle).
  function automatic int exp_cyc(input int sel, input int ack_at);
    if (sel >= NB) return 1;
    if (ack_at >= 1 && ack_at <= TO) return ack_at + 1;
    return TO + 1;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] v, input int n);
    int s;
    s = int'(v) + n;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  // Drives one request and a block responder, recording what the DUT did.
  task automatic run_xact(input bit rd, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input int ack_at, input int ack_blk, input logic [31:0] bdata,
                          input int stray_at, input int stray_blk, input bit clr, input int ncyc,
                          output int ack_cyc, output int ack_num, output logic [31:0] rdat,
                          output logic [NB-1:0] req_vec, output int req_num,
                          output logic [LAW-1:0] laddr, output logic [31:0] lwd,
                          output int to_cyc, output int dec_cyc, output logic [15:0] cnt1);
    logic [NB-1:0] rq;
    ack_cyc = -1; ack_num = 0; rdat = '0; req_vec = '0; req_num = 0;
    laddr = '0; lwd = '0; to_cyc = -1; dec_cyc = -1; cnt1 = '0;
    if (rd) begin up_rreq = 1'b1; up_raddr = addr; end
    else begin up_wreq = 1'b1; up_waddr = addr; up_wdata = wd; end
    err_clr = clr;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      up_rreq = 1'b0; up_wreq = 1'b0; err_clr = 1'b0;
      rq = rd ? blk_rreq : blk_wreq;
      if (k == 1) begin
        req_vec = rq;
        laddr   = rd ? blk_raddr : blk_waddr;
        lwd     = blk_wdata;
        cnt1    = err_cnt;
      end
      if (rq != '0) req_num++;
      if (rd ? up_rack : up_wack) begin
        ack_num++;
        if (ack_cyc < 0) begin ack_cyc = k; rdat = up_rdata; end
      end
      if (err_timeout && to_cyc < 0) to_cyc = k;
      if (err_decode && dec_cyc < 0) dec_cyc = k;
      blk_wack = '0; blk_rack = '0;
      blk_rdata = {$urandom, $urandom, $urandom};
      if (k == ack_at) begin
        if (rd) blk_rack[ack_blk] = 1'b1; else blk_wack[ack_blk] = 1'b1;
        blk_rdata[32*ack_blk +: 32] = bdata;
      end
      if (k == stray_at) begin
        if (rd) blk_rack[stray_blk] = 1'b1; else blk_wack[stray_blk] = 1'b1;
      end
    end
    blk_wack = '0; blk_rack = '0;
  endtask

  task automatic test_reset();
    up_rstn = 1'b0; up_wreq = 0; up_rreq = 0; up_waddr = '0; up_raddr = '0; up_wdata = '0;
    blk_wack = '0; blk_rack = '0; blk_rdata = '0; err_clr = 0;
    step(); step();
    checks++;
    if ({up_wack, up_rack, blk_wreq, blk_rreq, err_timeout, err_decode} !== '0) begin
      errors++; $display("FAIL reset_strobes got %b want 0",
        {up_wack, up_rack, blk_wreq, blk_rreq, err_timeout, err_decode});
    end
    checks++;
    if ({up_rdata, blk_wdata, blk_waddr, blk_raddr, err_cnt} !== '0) begin
      errors++; $display("FAIL reset_data got rdata=%h wdata=%h waddr=%h raddr=%h cnt=%h want 0",
        up_rdata, blk_wdata, blk_waddr, blk_raddr, err_cnt);
    end
    up_rstn = 1'b1;
    step();
    exp_err = '0;
  endtask

  task automatic test_write_blk1();
    int ac, an, rn, tc, dc; logic [31:0] rdat, lwd; logic [NB-1:0] rv;
    logic [LAW-1:0] la; logic [15:0] c1;
    run_xact(0, 14'h0205, 32'hA5A5A5A5, 2, 1, '0, -1, 0, 0, 6, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
    checks++; if (rv !== 3'b010 || rn != 1) begin errors++; $display("FAIL wr_req got %b x%0d want 010 x1", rv, rn); end
    checks++; if (la !== 9'h005 || lwd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_addr_data got %h/%h want 005/a5a5a5a5", la, lwd); end
    checks++; if (ac != 3 || an != 1) begin errors++; $display("FAIL wr_ack got cyc %0d x%0d want 3 x1", ac, an); end
    checks++; if (tc != -1 || dc != -1 || err_cnt !== exp_err) begin errors++; $display("FAIL wr_noerr got to=%0d dec=%0d cnt=%0d want none cnt=%0d", tc, dc, err_cnt, exp_err); end
  endtask

  task automatic test_read_blk2();
    int ac, an, rn, tc, dc; logic [31:0] rdat, lwd; logic [NB-1:0] rv;
    logic [LAW-1:0] la; logic [15:0] c1;
    run_xact(1, 14'h0403, '0, 1, 2, 32'h12345678, -1, 0, 0, 5, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
    checks++; if (rv !== 3'b100 || la !== 9'h003) begin errors++; $display("FAIL rd_req got %b/%h want 100/003", rv, la); end
    checks++; if (ac != 2 || rdat !== 32'h12345678) begin errors++; $display("FAIL rd_ack got cyc %0d data %h want 2 12345678", ac, rdat); end
    checks++; if (up_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_hold got %h want 12345678", up_rdata); end
  endtask

  task automatic test_read_decode();
    int ac, an, rn, tc, dc; logic [31:0] rdat, lwd; logic [NB-1:0] rv;
    logic [LAW-1:0] la; logic [15:0] c1;
    run_xact(1, 14'h0A00, '0, 1, 0, '0, -1, 0, 0, 4, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
    exp_err = sat_add(exp_err, 1);
    checks++; if (rn != 0) begin errors++; $display("FAIL dec_noreq got %0d req cycles want 0", rn); end
    checks++; if (ac != 1 || rdat !== ED || dc != 1) begin errors++; $display("FAIL dec_ack got cyc %0d data %h dec %0d want 1 deaddead 1", ac, rdat, dc); end
    checks++; if (c1 !== exp_err) begin errors++; $display("FAIL dec_cnt got %0d want %0d", c1, exp_err); end
  endtask

  task automatic test_timeout();
    int ac, an, rn, tc, dc; logic [31:0] rdat, lwd; logic [NB-1:0] rv;
    logic [LAW-1:0] la; logic [15:0] c1;
    run_xact(0, 14'h0011, 32'h1, 20, 0, '0, -1, 0, 0, 24, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
    exp_err = sat_add(exp_err, 1);
    checks++; if (ac != TO + 1 || tc != TO + 1 || an != 1) begin errors++; $display("FAIL to_wr got ack %0d to %0d x%0d want %0d %0d x1", ac, tc, an, TO + 1, TO + 1); end
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL to_cnt got %0d want %0d", err_cnt, exp_err); end
    // Ack on the last counted cycle still counts as a normal completion.
    run_xact(1, 14'h0022, '0, TO, 0, 32'hCAFE0001, -1, 0, 0, 20, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
    checks++; if (ac != TO + 1 || rdat !== 32'hCAFE0001 || tc != -1) begin errors++; $display("FAIL to_edge got ack %0d data %h to %0d want %0d cafe0001 -1", ac, rdat, tc, TO + 1); end
    run_xact(1, 14'h0022, '0, TO + 1, 0, 32'hCAFE0002, -1, 0, 0, 20, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
    exp_err = sat_add(exp_err, 1);
    checks++; if (ac != TO + 1 || rdat !== ED || tc != TO + 1 || an != 1) begin errors++; $display("FAIL to_rd got ack %0d data %h to %0d x%0d want %0d deaddead", ac, rdat, tc, an, TO + 1); end
  endtask

  task automatic test_stray();
    int ac, an, rn, tc, dc; logic [31:0] rdat, lwd; logic [NB-1:0] rv;
    logic [LAW-1:0] la; logic [15:0] c1;
    run_xact(1, 14'h0007, '0, 4, 0, 32'h0BADF00D, 1, 1, 0, 8, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
    checks++; if (ac != 5 || an != 1 || rdat !== 32'h0BADF00D) begin errors++; $display("FAIL stray got ack %0d x%0d data %h want 5 x1 0badf00d", ac, an, rdat); end
  endtask

  task automatic test_concurrent();
    int wc = -1, rc = -1; logic [31:0] rd_at = '0; logic [NB-1:0] wv = '0, rv = '0;
    up_wreq = 1; up_waddr = 14'h0010; up_wdata = 32'h55AA55AA;
    up_rreq = 1; up_raddr = 14'h0403;
    for (int k = 1; k <= 8; k++) begin
      step();
      up_wreq = 0; up_rreq = 0;
      if (k == 1) begin wv = blk_wreq; rv = blk_rreq; end
      if (up_wack && wc < 0) wc = k;
      if (up_rack && rc < 0) begin rc = k; rd_at = up_rdata; end
      blk_wack = '0; blk_rack = '0; blk_rdata = {$urandom, $urandom, $urandom};
      if (k == 1) begin blk_rack[2] = 1'b1; blk_rdata[64 +: 32] = 32'h600DDA7A; end
      if (k == 3) blk_wack[0] = 1'b1;
    end
    blk_wack = '0; blk_rack = '0;
    checks++; if (wv !== 3'b001 || rv !== 3'b100) begin errors++; $display("FAIL conc_req got w=%b r=%b want 001 100", wv, rv); end
    checks++; if (rc != 2 || wc != 4 || rd_at !== 32'h600DDA7A) begin errors++; $display("FAIL conc_ack got r=%0d w=%0d data %h want 2 4 600dda7a", rc, wc, rd_at); end
    checks++; if (err_cnt !== exp_err || blk_wdata !== 32'h55AA55AA) begin errors++; $display("FAIL conc_state got cnt %0d wdata %h want %0d 55aa55aa", err_cnt, blk_wdata, exp_err); end
  endtask

  task automatic test_dual_error();
    int tc = -1, dc = -1; logic [15:0] c17 = '0;
    up_wreq = 1; up_waddr = 14'h0001; up_wdata = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      up_wreq = 0; up_rreq = 0;
      if (err_timeout && tc < 0) tc = k;
      if (err_decode && dc < 0) dc = k;
      if (k == TO + 1) c17 = err_cnt;
      if (k == TO) begin up_rreq = 1; up_raddr = 14'h0C00; end
    end
    exp_err = sat_add(exp_err, 2);
    checks++; if (tc != TO + 1 || dc != TO + 1) begin errors++; $display("FAIL dual_pulse got to %0d dec %0d want %0d", tc, dc, TO + 1); end
    checks++; if (c17 !== exp_err) begin errors++; $display("FAIL dual_cnt got %0d want %0d", c17, exp_err); end
  endtask

  task automatic test_saturate();
    int ac, an, rn, tc, dc; logic [31:0] rdat, lwd; logic [NB-1:0] rv;
    logic [LAW-1:0] la; logic [15:0] c1;
    force dut.err_cnt_q = 16'hFFFE;
    #1;
    release dut.err_cnt_q;
    exp_err = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      run_xact(0, 14'h0800, '0, -1, 0, '0, -1, 0, 0, 3, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
      exp_err = sat_add(exp_err, 1);
      checks++; if (c1 !== exp_err) begin errors++; $display("FAIL sat_%0d got %h want %h", i, c1, exp_err); end
    end
  endtask

  task automatic test_clr();
    int ac, an, rn, tc, dc; logic [31:0] rdat, lwd; logic [NB-1:0] rv;
    logic [LAW-1:0] la; logic [15:0] c1;
    run_xact(1, 14'h0E00, '0, -1, 0, '0, -1, 0, 1, 3, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
    exp_err = '0;
    checks++; if (c1 !== 16'h0 || dc != 1) begin errors++; $display("FAIL clr got cnt %h dec %0d want 0 1", c1, dc); end
  endtask

  task automatic test_reset_mid();
    int ac, an, rn, tc, dc; logic [31:0] rdat, lwd; logic [NB-1:0] rv;
    logic [LAW-1:0] la; logic [15:0] c1; int late = 0;
    up_rreq = 1; up_raddr = 14'h0204;
    step(); up_rreq = 0; step(); step();
    up_rstn = 0;
    #1;
    checks++;
    if ({up_wack, up_rack, blk_wreq, blk_rreq, err_timeout, err_decode, up_rdata, err_cnt} !== '0) begin
      errors++; $display("FAIL rstmid_out got rack=%b rreq=%b rdata=%h cnt=%h want 0", up_rack, blk_rreq, up_rdata, err_cnt);
    end
    step(); step();
    up_rstn = 1;
    exp_err = '0;
    step();
    blk_rack[1] = 1'b1;
    for (int k = 0; k < TO + 4; k++) begin
      step();
      blk_rack = '0;
      if (up_rack || err_timeout) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL rstmid_noack got %0d ack cycles want 0", late); end
    run_xact(1, 14'h0204, '0, 2, 1, 32'h0A0B0C0D, -1, 0, 0, 5, ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
    checks++; if (ac != 3 || rdat !== 32'h0A0B0C0D || rv !== 3'b010) begin errors++; $display("FAIL rstmid_after got cyc %0d data %h req %b want 3 0a0b0c0d 010", ac, rdat, rv); end
  endtask

  task automatic test_random();
    int ac, an, rn, tc, dc; logic [31:0] rdat, lwd; logic [NB-1:0] rv;
    logic [LAW-1:0] la; logic [15:0] c1;
    for (int t = 0; t < 24; t++) begin
      bit rd; int sel, ack_at, ec; logic [LAW-1:0] loc; logic [31:0] wd, bd;
      logic [NB-1:0] erv; bit err;
      rd = 1'($urandom); sel = int'($urandom_range(0, 4)); loc = LAW'($urandom);
      ack_at = int'($urandom_range(1, 20)); wd = $urandom; bd = $urandom;
      ec  = exp_cyc(sel, ack_at);
      erv = (sel < NB) ? NB'(1 << sel) : '0;
      err = (sel >= NB) || (ack_at > TO);
      run_xact(rd, {SW'(sel), loc}, wd, ack_at, (sel < NB) ? sel : 0, bd, -1, 0, 0, 22,
               ac, an, rdat, rv, rn, la, lwd, tc, dc, c1);
      if (err) exp_err = sat_add(exp_err, 1);
      checks++;
      if (rv !== erv || ac != ec || an != 1) begin
        errors++; $display("FAIL rnd%0d_ack rd=%0d sel=%0d at=%0d got req %b cyc %0d x%0d want %b %0d x1",
          t, rd, sel, ack_at, rv, ac, an, erv, ec);
      end
      if (rd) begin
        checks++;
        if (rdat !== (err ? ED : bd)) begin errors++; $display("FAIL rnd%0d_data got %h want %h", t, rdat, err ? ED : bd); end
      end
      if (sel < NB) begin
        checks++;
        if (la !== loc || (!rd && lwd !== wd)) begin errors++; $display("FAIL rnd%0d_addr got %h/%h want %h/%h", t, la, lwd, loc, wd); end
      end
      checks++;
      if (err_cnt !== exp_err || (tc != -1) != (sel < NB && ack_at > TO) || (dc != -1) != (sel >= NB)) begin
        errors++; $display("FAIL rnd%0d_err got cnt %0d to %0d dec %0d want cnt %0d", t, err_cnt, tc, dc, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_blk1();
    test_read_blk2();
    test_read_decode();
    test_timeout();
    test_stray();
    test_concurrent();
    test_dual_error();
    test_saturate();
    test_clr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
